// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into one register-file write port.
// Latency: an offer accepted at edge k into an empty queue writes during cycle k+1.
// Backpressure: a 2-entry queue; both READYs drop when it is full, HOLD stalls the write port.
//
// Ports:
//   clk_i, reset_i                      - clock, synchronous active-high reset
//   alu_valid_i/alu_rd_i/alu_data_i     - ALU result offer, alu_ready_o accepts it
//   mem_valid_i/mem_rd_i/mem_data_i     - load-unit result offer, mem_ready_o accepts it
//   hold_i                              - register-file write port unavailable
//   rd_o/rd_data_o/write_enable_o       - register-file write port (queue head)
//   q1_i/q2_i, fwd*_hit_o/fwd*_data_o   - forwarding lookups against queued entries
//   pending_o                           - number of queued writes (0..2)

module writeback_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  input  logic        hold_i,
  output logic [4:0]  rd_o,
  output logic [31:0] rd_data_o,
  output logic        write_enable_o,
  input  logic [4:0]  q1_i,
  input  logic [4:0]  q2_i,
  output logic        fwd1_hit_o,
  output logic [31:0] fwd1_data_o,
  output logic        fwd2_hit_o,
  output logic [31:0] fwd2_data_o,
  output logic [1:0]  pending_o
);

  // Queue storage; contents are only meaningful for live slots, so no reset.
  logic [4:0]  ent_rd_q   [2];
  logic [31:0] ent_data_q [2];

  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q,  count_d;
  logic [2:0]  starve_q, starve_d;

  logic        accept_ok;
  logic        alu_priority;
  logic        alu_grant;
  logic        mem_grant;
  logic        push;
  logic        pop;
  logic [4:0]  push_rd;
  logic [31:0] push_data;

  // Slot views: "old" is the head, "young" is the slot behind it.
  logic        old_live;
  logic        young_live;
  logic [4:0]  old_rd;
  logic [31:0] old_data;
  logic [4:0]  young_rd;
  logic [31:0] young_data;
  logic [32:0] fwd1_res;
  logic [32:0] fwd2_res;

  // Youngest match wins so a later write to the same register shadows an older one.
  function automatic logic [32:0] fwd_lookup(
    input logic [4:0]  q,
    input logic        y_live,
    input logic [4:0]  y_rd,
    input logic [31:0] y_data,
    input logic        o_live,
    input logic [4:0]  o_rd,
    input logic [31:0] o_data
  );
    logic [32:0] res;
    res = '0;
    if (q != 5'd0) begin
      if (y_live && (y_rd == q)) begin
        res = {1'b1, y_data};
      end else if (o_live && (o_rd == q)) begin
        res = {1'b1, o_data};
      end
    end
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Grant and queue control
  // ------------------------------------------------------------------
  always_comb begin
    // Acceptance looks only at the registered occupancy; a pop in the same
    // cycle does not open a slot early, which keeps READY free of HOLD.
    accept_ok    = !reset_i && (count_q != 2'd2);
    alu_priority = (starve_q >= 3'd4);

    mem_grant = accept_ok && mem_valid_i && !(alu_valid_i && alu_priority);
    alu_grant = accept_ok && alu_valid_i && (!mem_valid_i || alu_priority);

    push_rd   = mem_grant ? mem_rd_i   : alu_rd_i;
    push_data = mem_grant ? mem_data_i : alu_data_i;

    // Writes to x0 complete the handshake but never occupy the queue.
    push = (mem_grant || alu_grant) && (push_rd != 5'd0);
    pop  = !reset_i && (count_q != 2'd0) && !hold_i;

    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Starvation counter saturates at 7; priority kicks in from 4 upward so
    // a full queue cannot make ALU miss its turn.
    starve_d = starve_q;
    if (!alu_valid_i || alu_grant) begin
      starve_d = 3'd0;
    end else if (starve_q != 3'd7) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= push_rd;
      ent_data_q[wr_ptr_q] <= push_data;
    end
  end

  // ------------------------------------------------------------------
  // Write port and forwarding
  // ------------------------------------------------------------------
  always_comb begin
    // Gating with reset hides stale occupancy during the reset cycle itself.
    old_live   = !reset_i && (count_q != 2'd0);
    young_live = !reset_i && (count_q == 2'd2);

    old_rd     = ent_rd_q[rd_ptr_q];
    old_data   = ent_data_q[rd_ptr_q];
    young_rd   = ent_rd_q[~rd_ptr_q];
    young_data = ent_data_q[~rd_ptr_q];

    fwd1_res = fwd_lookup(q1_i, young_live, young_rd, young_data, old_live, old_rd, old_data);
    fwd2_res = fwd_lookup(q2_i, young_live, young_rd, young_data, old_live, old_rd, old_data);
  end

  assign alu_ready_o    = alu_grant;
  assign mem_ready_o    = mem_grant;
  assign write_enable_o = pop;
  assign rd_o           = old_live ? old_rd   : 5'd0;
  assign rd_data_o      = old_live ? old_data : 32'd0;
  assign fwd1_hit_o     = fwd1_res[32];
  assign fwd1_data_o    = fwd1_res[31:0];
  assign fwd2_hit_o     = fwd2_res[32];
  assign fwd2_data_o    = fwd2_res[31:0];
  assign pending_o      = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, single write, ordering under HOLD,
// forwarding, starvation override, x0 discard and mid-operation reset.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.

module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        hold;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        we;
  logic [4:0]  q1;
  logic [4:0]  q2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [1:0]  pending;

  int checks = 0;
  int errors = 0;

  writeback_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .alu_valid_i    (alu_valid),
    .alu_rd_i       (alu_rd),
    .alu_data_i     (alu_data),
    .alu_ready_o    (alu_ready),
    .mem_valid_i    (mem_valid),
    .mem_rd_i       (mem_rd),
    .mem_data_i     (mem_data),
    .mem_ready_o    (mem_ready),
    .hold_i         (hold),
    .rd_o           (rd),
    .rd_data_o      (rd_data),
    .write_enable_o (we),
    .q1_i           (q1),
    .q2_i           (q2),
    .fwd1_hit_o     (fwd1_hit),
    .fwd1_data_o    (fwd1_data),
    .fwd2_hit_o     (fwd2_hit),
    .fwd2_data_o    (fwd2_data),
    .pending_o      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h5678;
    q1 = 5'd5; q2 = 5'd3;
    step(); step();
    #1;
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if ({rd, rd_data} !== 37'd0) begin errors++; $display("FAIL reset_port: got rd=%0d data=%h want 0", rd, rd_data); end
    checks++; if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== 66'd0) begin errors++; $display("FAIL reset_fwd: got %b/%h %b/%h want 0", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data); end
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; q1 = 5'd0; q2 = 5'd0;
    step();
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_we_before: got %b want 0", we); end
    step();
    alu_valid = 1'b0;
    #1;
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", we); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d want 5", rd); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", rd_data); end
    checks++; if (pending !== 2'd1) begin errors++; $display("FAIL single_pending1: got %0d want 1", pending); end
    step();
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL single_pending0: got %0d want 0", pending); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_we_after: got %b want 0", we); end
  endtask

  task automatic test_hold_order();
    hold = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    #1;
    checks++; if ({mem_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL order_first_grant: got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if ({mem_ready, alu_ready} !== 2'b01) begin errors++; $display("FAIL order_second_grant: got mem=%b alu=%b want mem=0 alu=1", mem_ready, alu_ready); end
    step();
    // A further ALU offer stays pending while the queue is full.
    alu_rd = 5'd9; alu_data = 32'h33;
    #1;
    checks++; if (pending !== 2'd2) begin errors++; $display("FAIL order_full: got %0d want 2", pending); end
    checks++; if ({mem_ready, alu_ready} !== 2'b00) begin errors++; $display("FAIL order_full_ready: got mem=%b alu=%b want 0", mem_ready, alu_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL order_hold_we: got %b want 0", we); end
    hold = 1'b0;
    #1;
    checks++; if ({we, rd, rd_data} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL order_write1: got we=%b rd=%0d data=%h want 1/3/11", we, rd, rd_data); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL order_pop_ready: got %b want 0", alu_ready); end
    step();
    #1;
    checks++; if ({we, rd, rd_data} !== {1'b1, 5'd4, 32'h22}) begin errors++; $display("FAIL order_write2: got we=%b rd=%0d data=%h want 1/4/22", we, rd, rd_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL order_reopen: got %b want 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    #1;
    checks++; if ({we, rd, rd_data, pending} !== {1'b1, 5'd9, 32'h33, 2'd1}) begin errors++; $display("FAIL order_pushpop: got we=%b rd=%0d data=%h pend=%0d want 1/9/33/1", we, rd, rd_data, pending); end
    step();
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL order_drain: got %0d want 0", pending); end
  endtask

  task automatic test_forwarding();
    hold = 1'b1;
    q1 = 5'd7; q2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    #1;
    checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd_not_inflight: got %b want 0", fwd1_hit); end
    step();
    alu_data = 32'hB;
    #1;
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'hA}) begin errors++; $display("FAIL fwd_one_entry: got %b/%h want 1/a", fwd1_hit, fwd1_data); end
    step();
    alu_valid = 1'b0;
    #1;
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'hB}) begin errors++; $display("FAIL fwd_youngest: got %b/%h want 1/b", fwd1_hit, fwd1_data); end
    checks++; if ({fwd2_hit, fwd2_data} !== 33'd0) begin errors++; $display("FAIL fwd_q_zero: got %b/%h want 0/0", fwd2_hit, fwd2_data); end
    q2 = 5'd9;
    #1;
    checks++; if ({fwd2_hit, fwd2_data} !== 33'd0) begin errors++; $display("FAIL fwd_miss: got %b/%h want 0/0", fwd2_hit, fwd2_data); end
    hold = 1'b0;
    step(); step();
    checks++; if ({pending, fwd1_hit} !== 3'b000) begin errors++; $display("FAIL fwd_drained: got pend=%0d hit=%b want 0/0", pending, fwd1_hit); end
    // Distinct registers in both slots, pointers now advanced past the start.
    hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hC;
    step();
    alu_rd = 5'd8; alu_data = 32'hD;
    step();
    alu_valid = 1'b0; q1 = 5'd7; q2 = 5'd8;
    #1;
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'hC}) begin errors++; $display("FAIL fwd_older: got %b/%h want 1/c", fwd1_hit, fwd1_data); end
    checks++; if ({fwd2_hit, fwd2_data} !== {1'b1, 32'hD}) begin errors++; $display("FAIL fwd_second: got %b/%h want 1/d", fwd2_hit, fwd2_data); end
    hold = 1'b0;
    step(); step();
    q1 = 5'd0; q2 = 5'd0;
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL fwd_final_drain: got %0d want 0", pending); end
  endtask

  task automatic test_starvation();
    hold = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h100;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h200;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++;
      if ({mem_ready, alu_ready} !== ((c == 5) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL starve_cycle%0d: got mem=%b alu=%b", c, mem_ready, alu_ready);
      end
      step();
    end
    #1;
    checks++; if ({mem_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL starve_cleared: got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready); end
    checks++; if ({we, rd, rd_data} !== {1'b1, 5'd11, 32'h200}) begin errors++; $display("FAIL starve_write: got we=%b rd=%0d data=%h want 1/11/200", we, rd, rd_data); end
    mem_valid = 1'b0; alu_valid = 1'b0;
    step(); step();
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL starve_drain: got %0d want 0", pending); end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
    #1;
    checks++; if ({pending, we} !== 3'b000) begin errors++; $display("FAIL x0_alu_discard: got pend=%0d we=%b want 0/0", pending, we); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL x0_mem_ready: got %b want 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if ({pending, we} !== 3'b000) begin errors++; $display("FAIL x0_mem_discard: got pend=%0d we=%b want 0/0", pending, we); end
  endtask

  task automatic test_reset_midflight();
    hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
    step();
    alu_rd = 5'd13; alu_data = 32'h13;
    step();
    alu_rd = 5'd14; alu_data = 32'h14; q1 = 5'd12;
    #1;
    checks++; if (pending !== 2'd2) begin errors++; $display("FAIL rst_mid_full: got %0d want 2", pending); end
    reset = 1'b1;
    #1;
    checks++; if ({alu_ready, mem_ready, we} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl: got alu=%b mem=%b we=%b want 0", alu_ready, mem_ready, we); end
    checks++; if ({rd, rd_data, fwd1_hit, fwd1_data} !== 70'd0) begin errors++; $display("FAIL rst_mid_data: got rd=%0d data=%h hit=%b fwd=%h want 0", rd, rd_data, fwd1_hit, fwd1_data); end
    step();
    reset = 1'b0; hold = 1'b0;
    #1;
    checks++; if ({pending, we} !== 3'b000) begin errors++; $display("FAIL rst_mid_cleared: got pend=%0d we=%b want 0/0", pending, we); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_resume: got %b want 1", alu_ready); end
    step();
    alu_valid = 1'b0; q1 = 5'd0;
    #1;
    checks++; if ({we, rd, rd_data} !== {1'b1, 5'd14, 32'h14}) begin errors++; $display("FAIL rst_mid_write: got we=%b rd=%0d data=%h want 1/14/14", we, rd, rd_data); end
    step();
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL rst_mid_drain: got %0d want 0", pending); end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    q1 = 5'd0; q2 = 5'd0;
    test_reset();
    test_single_write();
    test_hold_order();
    test_forwarding();
    test_starvation();
    test_rd_zero();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have CLK input 1: single clock; all state updates on rising edge.
REQ-002 SHALL have RESET input 1: synchronous reset, active-high.
REQ-003 SHALL have ALU_VALID input 1, ALU_RD input 5, ALU_DATA input 32: ALU result offer.
REQ-004 SHALL have ALU_READY output 1: ALU offer accepted when ALU_VALID && ALU_READY at an edge.
REQ-005 SHALL have MEM_VALID input 1, MEM_RD input 5, MEM_DATA input 32: load-unit result offer.
REQ-006 SHALL have MEM_READY output 1: MEM offer accepted when MEM_VALID && MEM_READY at an edge.
REQ-007 SHALL have HOLD input 1: register-file write port unavailable; blocks commit.
REQ-008 SHALL have RD output 5, RD_DATA output 32, WRITE_ENABLE output 1: write port to register file.
REQ-009 SHALL have Q1 input 5, Q2 input 5: forwarding query register indices.
REQ-010 SHALL have FWD1_HIT output 1, FWD1_DATA output 32, FWD2_HIT output 1, FWD2_DATA output 32: forwarding results.
REQ-011 SHALL have PENDING output 2: number of queued writes (0..2).

Function
REQ-012 SHALL hold a 2-entry in-order FIFO of {rd[4:0], data[31:0]}.
REQ-013 SHALL accept at most one offer per edge; at most one of ALU_READY, MEM_READY high per cycle.
REQ-014 Grant: when PENDING<2, MEM granted if MEM_VALID, else ALU granted if ALU_VALID; starvation override per REQ-015.
REQ-015 SHALL count consecutive cycles with ALU_VALID high and ALU not granted (3-bit saturating); at count 4, ALU granted next eligible cycle over MEM; counter clears when ALU granted or ALU_VALID low.
REQ-016 READY of the granted source SHALL be high combinationally when PENDING<2 and RESET low; both READYs low when PENDING==2 (even if a pop occurs same cycle).
REQ-017 Accepted offer with rd==0 SHALL complete the handshake and be discarded (not enqueued, PENDING unchanged, no write).
REQ-018 WRITE_ENABLE SHALL equal (PENDING>0 && !HOLD); RD/RD_DATA SHALL equal FIFO head whenever PENDING>0, else 0.
REQ-019 Head SHALL pop at each edge where WRITE_ENABLE is high.
REQ-020 Simultaneous push and pop: PENDING unchanged, order preserved; new entry lands behind remaining entries.
REQ-021 Latency: offer accepted at edge k with empty FIFO and HOLD low -> WRITE_ENABLE high during cycle k+1, cleared after edge k+1 unless more pending.
REQ-022 Forwarding (combinational): FWDn_HIT=1 when Qn!=0 and any queued entry has rd==Qn; FWDn_DATA = data of youngest matching entry; else FWDn_HIT=0, FWDn_DATA=0.
REQ-023 Forwarding SHALL consider only queued entries, not offers being accepted in the current cycle.
REQ-024 Read and write pointers SHALL wrap modulo 2; PENDING SHALL never exceed 2 nor underflow.
REQ-025 HOLD SHALL not affect acceptance; with HOLD high, FIFO fills to 2 and READYs drop.

Reset
REQ-026 RESET high at an edge SHALL set PENDING=0, pointers=0, starvation counter=0, discarding queued entries.
REQ-027 While RESET high: ALU_READY=0, MEM_READY=0, WRITE_ENABLE=0, RD=0, RD_DATA=0, FWD1/2_HIT=0, FWD1/2_DATA=0.
REQ-028 RESET asserted mid-operation SHALL drop in-flight entries with no write; first accept possible the cycle after RESET deasserts.

Verification
REQ-029 Empty, ALU offers rd=5 data=0xDEADBEEF -> ALU_READY=1; next cycle WRITE_ENABLE=1, RD=5, RD_DATA=0xDEADBEEF; PENDING 0 after following edge.
REQ-030 MEM(rd=3,0x11) and ALU(rd=4,0x22) both valid, HOLD=1 -> MEM accepted first, ALU second; PENDING=2, both READY=0; release HOLD -> writes rd3 then rd4 in consecutive cycles.
REQ-031 Two queued entries rd=7 (0xA then 0xB), HOLD=1, Q1=7, Q2=0 -> FWD1_HIT=1, FWD1_DATA=0xB; FWD2_HIT=0.
REQ-032 MEM_VALID and ALU_VALID held high continuously, HOLD=0 -> ALU granted no later than 5th cycle; counter clears after grant.
REQ-033 ALU offer rd=0 data=0x55 -> handshake completes, PENDING stays 0, WRITE_ENABLE stays 0.
REQ-034 PENDING=2 with HOLD=1, assert RESET one cycle -> PENDING=0, no WRITE_ENABLE pulse, READYs 0 during reset, accept resumes next cycle.
